// File: rtl/lv_frame_scheduler_pkg.sv
// Shared types for the LED-visualizer frame scheduler: note entry layout,
// scheduler FSM states and default counter widths.
package lv_frame_scheduler_pkg;

    localparam int LV_FCNT_W = 16;
    localparam int LV_AMP_W  = 16;
    localparam int LV_KEY_W  = 8;

    typedef struct packed {
        logic [LV_KEY_W-1:0] key;
        logic [LV_AMP_W-1:0] amplitude;
    } note_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        WAIT
    } lv_sched_state_t;

endpackage

// File: rtl/lv_frame_scheduler_tick.sv
// Free-running frame timer: counts 0..PERIOD-1 and raises tick while the
// count sits at PERIOD-1; it never pauses.
module lv_frame_tick #(
    parameter int PERIOD = 200000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]  LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: combinational blocks assign every output on every path, so no latch is inferred.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // NOTE: flops update with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lv_frame_scheduler.sv
// Frame-rate controller between the note pipeline and the LED visualizer/driver.
// Optional watchdog on the WAIT state is built when LV_SCHED_WATCHDOG_EN is defined.
module lv_frame_scheduler
    import lv_frame_scheduler_pkg::*;
#(
    parameter int BIN_QTY     = 12,
    parameter int FREQ        = 12_000_000,
    parameter int FRAME_HZ    = 60,
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int FCNT_W      = LV_FCNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  note_t [BIN_QTY-1:0]     notes_in,
    input  logic                    notes_valid,
    output note_t [BIN_QTY-1:0]     notes_out,
    output logic                    lv_start,
    input  logic                    lv_done,
    output logic                    busy,
    output logic [FCNT_W-1:0]       frame_count,
    output logic                    dropped,
    output logic                    overrun,
    output logic                    timeout
);

    localparam int P = FREQ / FRAME_HZ;

    logic tick;

    lv_frame_tick #(
        .PERIOD (P)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    lv_sched_state_t         state_q, state_d;
    logic                    tick_pending_q, tick_pending_d;
    logic                    pending_q, pending_d;
    note_t [BIN_QTY-1:0]     shadow_q, shadow_d;
    note_t [BIN_QTY-1:0]     notes_out_q, notes_out_d;
    logic                    lv_start_q, lv_start_d;
    logic                    busy_q, busy_d;
    logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
    logic                    dropped_q, dropped_d;
    logic                    overrun_q, overrun_d;

`ifdef LV_SCHED_WATCHDOG_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d        = state_q;
        tick_pending_d = tick_pending_q;
        pending_d      = pending_q;
        shadow_d       = shadow_q;
        notes_out_d    = notes_out_q;
        fcnt_d         = fcnt_q;
        overrun_d      = overrun_q;
`ifdef LV_SCHED_WATCHDOG_EN
        timeout_d      = timeout_q;
        wd_cnt_d       = (state_q == WAIT) ? wd_cnt_q + WD_W'(1) : '0;
`endif

        case (state_q)
            IDLE:  if (tick_pending_q) state_d = LOAD;
            LOAD: begin
                // Reissuing the held set when nothing new arrived refreshes the strip.
                state_d        = START;
                notes_out_d    = shadow_q;
                pending_d      = 1'b0;
                tick_pending_d = 1'b0;
            end
            START: state_d = WAIT;
            WAIT: begin
                if (lv_done) begin
                    state_d = IDLE;
                    fcnt_d  = fcnt_q + FCNT_W'(1);
                end
`ifdef LV_SCHED_WATCHDOG_EN
                else if (wd_cnt_q == WD_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // A tick during LOAD must survive the clear so the next frame still launches.
        if (tick) begin
            tick_pending_d = 1'b1;
            if (state_q != IDLE) overrun_d = 1'b1;
        end

        // Capture after the LOAD clear: a set arriving in LOAD stays pending for the next frame.
        if (notes_valid) begin
            shadow_d  = notes_in;
            pending_d = 1'b1;
        end

        dropped_d  = notes_valid && pending_q && (state_q != LOAD);
        lv_start_d = (state_d == START);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            tick_pending_q <= 1'b0;
            pending_q      <= 1'b0;
            // NOTE: the note buffers are reset too, so notes_out reads as all-zero notes after reset.
            shadow_q       <= '0;
            notes_out_q    <= '0;
            lv_start_q     <= 1'b0;
            busy_q         <= 1'b0;
            fcnt_q         <= '0;
            dropped_q      <= 1'b0;
            overrun_q      <= 1'b0;
`ifdef LV_SCHED_WATCHDOG_EN
            wd_cnt_q       <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            tick_pending_q <= tick_pending_d;
            pending_q      <= pending_d;
            shadow_q       <= shadow_d;
            notes_out_q    <= notes_out_d;
            lv_start_q     <= lv_start_d;
            busy_q         <= busy_d;
            fcnt_q         <= fcnt_d;
            dropped_q      <= dropped_d;
            overrun_q      <= overrun_d;
`ifdef LV_SCHED_WATCHDOG_EN
            wd_cnt_q       <= wd_cnt_d;
            timeout_q      <= timeout_d;
`endif
        end
    end

    assign notes_out   = notes_out_q;
    assign lv_start    = lv_start_q;
    assign busy        = busy_q;
    assign frame_count = fcnt_q;
    assign dropped     = dropped_q;
    assign overrun     = overrun_q;

`ifdef LV_SCHED_WATCHDOG_EN
    assign timeout = timeout_q;
`else
    // No watchdog is built; the expression is constant zero for any legal limit.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_lv_frame_scheduler.sv
// Scoreboard bench for lv_frame_scheduler: a frame-schedule model predicts each
// launch, drop and status flag; a separate monitor compares what the DUT presents.
module tb_lv_frame_scheduler;
    import lv_frame_scheduler_pkg::*;

    localparam int BIN_QTY     = 12;
    localparam int FREQ        = 1000;
    localparam int FRAME_HZ    = 100;
    localparam int P           = FREQ / FRAME_HZ;
    localparam int TIMEOUT_CYC = 20;
    localparam int NV          = BIN_QTY * $bits(note_t);

    typedef logic [NV-1:0] cv_t;
    typedef note_t [BIN_QTY-1:0] notes_t;

    typedef struct {
        int     cyc;
        notes_t notes;
    } start_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    notes_t      notes_in;
    notes_t      notes_out;
    logic        notes_valid;
    logic        lv_start;
    logic        lv_done;
    logic        busy;
    logic [15:0] frame_count;
    logic        dropped;
    logic        overrun;
    logic        timeout;

    lv_frame_scheduler #(
        .BIN_QTY     (BIN_QTY),
        .FREQ        (FREQ),
        .FRAME_HZ    (FRAME_HZ),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .FCNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .notes_in    (notes_in),
        .notes_valid (notes_valid),
        .notes_out   (notes_out),
        .lv_start    (lv_start),
        .lv_done     (lv_done),
        .busy        (busy),
        .frame_count (frame_count),
        .dropped     (dropped),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input cv_t act, input cv_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (frame schedule level) ----------------
    start_exp_t  exp_start_q[$];
    int          exp_drop_q[$];
    bit          m_active;
    int          m_load;
    int          m_unserved;
    int          m_last_done;
    bit          m_pending;
    notes_t      m_shadow;
    bit          nxt_overrun, vis_overrun;
    bit          nxt_timeout, vis_timeout;
    logic [15:0] nxt_fc, vis_fc;
    notes_t      nxt_notes, vis_notes;
    bit          vis_busy;

    task automatic model_reset();
        exp_start_q.delete();
        exp_drop_q.delete();
        m_active    = 1'b0;
        m_load      = 0;
        m_unserved  = -1;
        m_last_done = -100;
        m_pending   = 1'b0;
        m_shadow    = '0;
        nxt_overrun = 1'b0;
        vis_overrun = 1'b0;
        nxt_timeout = 1'b0;
        vis_timeout = 1'b0;
        nxt_fc      = '0;
        vis_fc      = '0;
        nxt_notes   = '0;
        vis_notes   = '0;
        vis_busy    = 1'b0;
    endtask

    // One cycle of the schedule: a frame loads 2 cycles after the oldest unserved
    // tick or 2 cycles after the previous frame's done, whichever is later.
    task automatic model_step(input int k, input logic v, input notes_t nin, input logic d);
        start_exp_t e;
        bit         load_now;
        int         ld;
        load_now    = 1'b0;
        vis_overrun = nxt_overrun;
        vis_timeout = nxt_timeout;
        vis_fc      = nxt_fc;
        vis_notes   = nxt_notes;
        if (!m_active && m_unserved >= 0) begin
            ld = (m_unserved > m_last_done) ? m_unserved + 2 : m_last_done + 2;
            if (k >= ld) begin
                load_now   = 1'b1;
                m_active   = 1'b1;
                m_load     = k;
                m_unserved = -1;
                nxt_notes  = m_shadow;
                e.cyc      = k + 1;
                e.notes    = m_shadow;
                exp_start_q.push_back(e);
            end
        end
        vis_busy = m_active;
        if (k % P == P - 1) begin
            if (m_active) nxt_overrun = 1'b1;
            if (m_unserved < 0) m_unserved = k;
        end
        if (load_now) m_pending = 1'b0;
        if (v) begin
            if (m_pending) exp_drop_q.push_back(k + 1);
            m_shadow  = nin;
            m_pending = 1'b1;
        end
        if (m_active && k >= m_load + 2) begin
            if (d) begin
                m_active    = 1'b0;
                m_last_done = k;
                nxt_fc      = nxt_fc + 16'd1;
            end
`ifdef LV_SCHED_WATCHDOG_EN
            else if (k == m_load + 1 + TIMEOUT_CYC) begin
                m_active    = 1'b0;
                m_last_done = k;
                nxt_timeout = 1'b1;
            end
`endif
        end
    endtask

    // ---------------- monitor ----------------
    int first_start_cyc = -1;
    int drops_seen      = 0;

    task automatic monitor_cycle();
        logic       exp_start;
        logic       exp_drop;
        start_exp_t e;
        exp_start = (exp_start_q.size() > 0) && (exp_start_q[0].cyc == cyc);
        check("lv_start", cv_t'(lv_start), cv_t'(exp_start));
        if (exp_start) begin
            e = exp_start_q.pop_front();
            if (lv_start) check("start_notes", cv_t'(notes_out), cv_t'(e.notes));
        end
        if (lv_start && first_start_cyc < 0) first_start_cyc = cyc;
        exp_drop = (exp_drop_q.size() > 0) && (exp_drop_q[0] == cyc);
        check("dropped", cv_t'(dropped), cv_t'(exp_drop));
        if (exp_drop) void'(exp_drop_q.pop_front());
        if (dropped) drops_seen++;
        check("overrun", cv_t'(overrun), cv_t'(vis_overrun));
        check("timeout", cv_t'(timeout), cv_t'(vis_timeout));
        check("frame_count", cv_t'(frame_count), cv_t'(vis_fc));
        check("busy", cv_t'(busy), cv_t'(vis_busy));
        check("notes_out", cv_t'(notes_out), cv_t'(vis_notes));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) monitor_cycle();
        end
    end

    // ---------------- stimulus and driver model ----------------
    int          done_at   = -1;
    int          valid_pct = 0;
    int          spur_pct  = 0;
    int          delay_min = 5;
    int          delay_max = 5;
    int          fv1       = -1;
    int          fv2       = -1;
    logic [15:0] fv1_amp   = '0;
    logic [15:0] fv2_amp   = '0;

    task automatic drive_cycle();
        notes_t n;
        logic   v;
        logic   d;
        for (int i = 0; i < BIN_QTY; i++) begin
            n[i].key       = 8'($urandom);
            n[i].amplitude = 16'($urandom);
        end
        v = 1'b0;
        if (valid_pct > 0 && int'($urandom_range(99, 0)) < valid_pct) v = 1'b1;
        if (cyc == fv1) begin
            v              = 1'b1;
            n[0].amplitude = fv1_amp;
        end
        if (cyc == fv2) begin
            v              = 1'b1;
            n[0].amplitude = fv2_amp;
        end
        if (lv_start) done_at = cyc + int'($urandom_range(delay_max, delay_min));
        d = (cyc == done_at) || (spur_pct > 0 && int'($urandom_range(99, 0)) < spur_pct);
        notes_in    = n;
        notes_valid = v;
        lv_done     = d;
        model_step(cyc, v, n, d);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            drive_cycle();
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        model_reset();
        rst             = 1'b0;
        cyc             = 0;
        done_at         = -1;
        fv1             = -1;
        fv2             = -1;
        first_start_cyc = -1;
        drive_cycle();
        mon_en = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lv_start"}, cv_t'(lv_start), '0);
        check({tag, "_busy"}, cv_t'(busy), '0);
        check({tag, "_frame_count"}, cv_t'(frame_count), '0);
        check({tag, "_dropped"}, cv_t'(dropped), '0);
        check({tag, "_overrun"}, cv_t'(overrun), '0);
        check({tag, "_timeout"}, cv_t'(timeout), '0);
        check({tag, "_notes_out"}, cv_t'(notes_out), '0);
    endtask

    initial begin
        int  drops_before;
        bit  found;
        rst         = 1'b1;
        notes_in    = '0;
        notes_valid = 1'b0;
        lv_done     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        release_reset();

        // First frame carries the captured set; then three idle periods reissue it.
        fv1     = 2;
        fv1_amp = 16'h0400;
        run_cycles(45);
        check("first_start_cycle", cv_t'(first_start_cyc), cv_t'(12));
        check("held_bin0_A", cv_t'(notes_out[0].amplitude), cv_t'(16'h0400));
        check("no_drops_A", cv_t'(drops_seen), '0);

        // Two sets inside one period: the first is overwritten, the second wins.
        for (int i = 0; i < P && (cyc % P) != 3; i++) run_cycles(1);
        fv1          = cyc + 1;
        fv1_amp      = 16'h0100;
        fv2          = cyc + 4;
        fv2_amp      = 16'h0200;
        drops_before = drops_seen;
        run_cycles(2 * P);
        check("one_drop_B", cv_t'(drops_seen - drops_before), cv_t'(1));
        check("latest_bin0_B", cv_t'(notes_out[0].amplitude), cv_t'(16'h0200));

        // Slow driver: ticks land mid-frame, so overrun must latch.
        delay_min = 25;
        delay_max = 25;
        run_cycles(70);
        check("overrun_C", cv_t'(overrun), cv_t'(1));
        delay_min = 5;
        delay_max = 5;
        run_cycles(30);

        // Randomised traffic, including done pulses outside WAIT.
        valid_pct = 20;
        spur_pct  = 5;
        delay_min = 1;
        delay_max = 14;
        run_cycles(400);

        // Asynchronous reset while a frame is in WAIT.
        valid_pct = 0;
        spur_pct  = 0;
        delay_min = 8;
        delay_max = 8;
        found     = 1'b0;
        for (int i = 0; i < 6 * P && !found; i++) begin
            run_cycles(1);
            found = lv_start;
        end
        check("start_before_reset", cv_t'(found), cv_t'(1));
        run_cycles(2);
        check("busy_before_reset", cv_t'(busy), cv_t'(1));
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        release_reset();
        delay_min = 5;
        delay_max = 5;
        run_cycles(45);
        check("first_start_after_reset", cv_t'(first_start_cyc), cv_t'(12));

        run_cycles(40);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
